tdm_demux2: RTL and testbench

TDM_DEMUX2 -- requirements
Module: tdm_demux2

---
 rtl/tdm_demux2.sv | 114 +++++++++++
 tb/tb_tdm_demux2.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux2.sv
// tdm_demux2: two-channel serial TDM demultiplexer.
// Slots alternate A/B, MSB first. A frame starts on sync with din_valid,
// and a sync arriving mid-frame discards the partial frame with an abort pulse.
// Optional feature: define TDM_PARITY_CHECK_EN to add a trailing even-parity
// slot. A frame whose parity fails leaves a_out/b_out unchanged and pulses par_err.
module tdm_demux2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             out_valid,
  output logic             abort,
  output logic             par_err
);

  localparam int SLOTS = 2 * WIDTH;
  localparam int CW    = $clog2(SLOTS + 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(SLOTS - 1);

`ifdef TDM_PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, RECV} state_t;
`endif

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-1:0] a_shift, b_shift;

  // Next value of each channel shift register if the current slot lands in it
  always_comb begin
    a_shift = (a_sh << 1) | WIDTH'(din);
    b_shift = (b_sh << 1) | WIDTH'(din);
  end

`ifndef TDM_PARITY_CHECK_EN
  assign par_err = 1'b0;
`endif

  // Frame FSM: slot capture, resync handling and registered output words/pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      a_out     <= '0;
      b_out     <= '0;
      out_valid <= 1'b0;
      abort     <= 1'b0;
`ifdef TDM_PARITY_CHECK_EN
      par_err   <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      abort     <= 1'b0;
`ifdef TDM_PARITY_CHECK_EN
      par_err   <= 1'b0;
`endif
      if (din_valid) begin
        if (sync) begin
          // sync always restarts at slot 0; anything in flight is discarded
          abort <= (state != IDLE);
          a_sh  <= WIDTH'(din);
          b_sh  <= '0;
          cnt   <= CW'(1);
          state <= RECV;
        end else begin
          case (state)
            IDLE: ;
            RECV: begin
              if (!cnt[0]) a_sh <= a_shift;
              else         b_sh <= b_shift;
              if (cnt == LAST_SLOT) begin
                cnt <= '0;
`ifdef TDM_PARITY_CHECK_EN
                state <= PAR;
`else
                a_out     <= a_sh;
                b_out     <= b_shift;
                out_valid <= 1'b1;
                state     <= IDLE;
`endif
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
`ifdef TDM_PARITY_CHECK_EN
            PAR: begin
              // Even parity: the parity bit equals the XOR of all data bits
              if ((^{a_sh, b_sh}) == din) begin
                a_out     <= a_sh;
                b_out     <= b_sh;
                out_valid <= 1'b1;
              end else begin
                par_err <= 1'b1;
              end
              state <= IDLE;
            end
`endif
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux2.sv
// Testbench for tdm_demux2 (WIDTH=4): directed vector table followed by
// randomized traffic checked against a frame-level reference model.
module tb_tdm_demux2;

  localparam int W = 4;
`ifdef TDM_PARITY_CHECK_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int FRAME_LEN = 2 * W + PAR_EN;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         din = 1'b0;
  logic         din_valid = 1'b0;
  logic         sync = 1'b0;
  logic [W-1:0] a_out, b_out;
  logic         out_valid, abort, par_err;

  tdm_demux2 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .a_out(a_out), .b_out(b_out), .out_valid(out_valid), .abort(abort),
    .par_err(par_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic         rst, dv, sy, d;
    logic [W-1:0] ea, eb;
    logic         eov, eab, epe;
  } vec_t;
  vec_t vt[$];

  // Reference model: collects accepted bits of the current frame in a queue
  bit           in_frame = 0;
  bit           bits[$];
  logic [W-1:0] m_a = '0, m_b = '0;
  logic         m_ov = 0, m_ab = 0, m_pe = 0;

  task automatic model_clock(input logic r, input logic dv, input logic sy, input logic d);
    int ones;
    m_ov = 0; m_ab = 0; m_pe = 0;
    if (r) begin
      in_frame = 0; bits.delete(); m_a = '0; m_b = '0;
    end else if (dv) begin
      if (sy) begin
        if (in_frame) m_ab = 1;
        bits.delete(); bits.push_back(d); in_frame = 1;
      end else if (in_frame) begin
        bits.push_back(d);
        if (bits.size() == FRAME_LEN) begin
          ones = 0;
          foreach (bits[k]) ones += int'(bits[k]);
          if (PAR_EN == 0 || ones % 2 == 0) begin
            for (int i = 0; i < W; i++) begin
              m_a[W-1-i] = bits[2*i];
              m_b[W-1-i] = bits[2*i+1];
            end
            m_ov = 1;
          end else begin
            m_pe = 1;
          end
          in_frame = 0; bits.delete();
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic dv, input logic sy, input logic d);
    rst = r; din_valid = dv; sync = sy; din = d;
    @(posedge clk);
    model_clock(r, dv, sy, d);
    #1;
  endtask

  task automatic check(input string name, input logic [2*W+2:0] got, input logic [2*W+2:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got a=%h b=%h ov=%b ab=%b pe=%b, expected a=%h b=%h ov=%b ab=%b pe=%b",
               name, got[2*W+2:W+3], got[W+2:3], got[2], got[1], got[0],
               exp[2*W+2:W+3], exp[W+2:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic add(input logic r, input logic dv, input logic sy, input logic d,
                     input logic [W-1:0] ea, input logic [W-1:0] eb,
                     input logic eov, input logic eab, input logic epe);
    vec_t v;
    v.rst = r; v.dv = dv; v.sy = sy; v.d = d;
    v.ea = ea; v.eb = eb; v.eov = eov; v.eab = eab; v.epe = epe;
    vt.push_back(v);
  endtask

  // Queue one full frame a/b; pa/pb are the words expected to be held until it lands
  task automatic add_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] pa, input logic [W-1:0] pb,
                           input logic par_bad, input int gap, input logic ab_first);
    logic p;
    for (int s = 0; s < 2 * W; s++) begin
      logic d;
      d = (s % 2 == 0) ? a[W-1-s/2] : b[W-1-s/2];
      if (s == 2 * W - 1 && PAR_EN == 0)
        add(0, 1, 0, d, a, b, 1, 0, 0);
      else
        add(0, 1, (s == 0), d, pa, pb, 0, (s == 0) && ab_first, 0);
      if (s == 3)
        for (int g = 0; g < gap; g++) add(0, 0, 0, 1, pa, pb, 0, 0, 0);
    end
    if (PAR_EN != 0) begin
      p = (^{a, b}) ^ par_bad;
      if (par_bad) add(0, 1, 0, p, pa, pb, 0, 0, 1);
      else         add(0, 1, 0, p, a, b, 1, 0, 0);
    end
  endtask

  initial begin
    // Reset state
    add(1, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
    // Idle noise: valid data without sync is ignored
    for (int i = 0; i < 10; i++) add(0, 1, 0, logic'(i % 2), 4'h0, 4'h0, 0, 0, 0);
    // Basic frame: din 1,0,0,1,1,1,0,0 -> a=1010 b=0110
    add_frame(4'b1010, 4'b0110, 4'h0, 4'h0, 0, 0, 0);
    add(0, 0, 0, 0, 4'b1010, 4'b0110, 0, 0, 0);
    add(0, 0, 0, 0, 4'b1010, 4'b0110, 0, 0, 0);
    // Same frame with a two-cycle gap between slots 3 and 4
    add_frame(4'b1010, 4'b0110, 4'b1010, 4'b0110, 0, 2, 0);
    // Resync at slot 3, then full frame a=0011 b=1100
    add(0, 1, 1, 1, 4'b1010, 4'b0110, 0, 0, 0);
    add(0, 1, 0, 0, 4'b1010, 4'b0110, 0, 0, 0);
    add(0, 1, 0, 0, 4'b1010, 4'b0110, 0, 0, 0);
    add_frame(4'b0011, 4'b1100, 4'b1010, 4'b0110, 0, 0, 1);
    // Reset at slot 5 of a frame, then a clean frame
    add(0, 1, 1, 1, 4'b0011, 4'b1100, 0, 0, 0);
    add(0, 1, 0, 0, 4'b0011, 4'b1100, 0, 0, 0);
    add(0, 1, 0, 0, 4'b0011, 4'b1100, 0, 0, 0);
    add(0, 1, 0, 1, 4'b0011, 4'b1100, 0, 0, 0);
    add(0, 1, 0, 1, 4'b0011, 4'b1100, 0, 0, 0);
    add(1, 1, 0, 1, 4'h0, 4'h0, 0, 0, 0);
    add_frame(4'b1010, 4'b0110, 4'h0, 4'h0, 0, 0, 0);
    // Sync on the final data slot discards the frame; the new frame is then resynced again
    add(0, 1, 1, 0, 4'b1010, 4'b0110, 0, 0, 0);
    add(0, 1, 0, 1, 4'b1010, 4'b0110, 0, 0, 0);
    add(0, 1, 0, 0, 4'b1010, 4'b0110, 0, 0, 0);
    add(0, 1, 0, 1, 4'b1010, 4'b0110, 0, 0, 0);
    add(0, 1, 0, 1, 4'b1010, 4'b0110, 0, 0, 0);
    add(0, 1, 0, 0, 4'b1010, 4'b0110, 0, 0, 0);
    add(0, 1, 0, 1, 4'b1010, 4'b0110, 0, 0, 0);
    add(0, 1, 1, 0, 4'b1010, 4'b0110, 0, 1, 0);
    add_frame(4'b0101, 4'b1001, 4'b1010, 4'b0110, 0, 0, 1);
    // Back-to-back frame: sync right after the last slot, no abort
    add_frame(4'b1110, 4'b0001, 4'b0101, 4'b1001, 0, 0, 0);
    // Bad parity keeps the held words
    if (PAR_EN != 0) add_frame(4'b1010, 4'b0110, 4'b1110, 4'b0001, 1, 0, 0);
    add(0, 0, 0, 0, 4'b1110, 4'b0001, 0, 0, 0);

    foreach (vt[i]) begin
      step(vt[i].rst, vt[i].dv, vt[i].sy, vt[i].d);
      check($sformatf("vec%0d", i), {a_out, b_out, out_valid, abort, par_err},
            {vt[i].ea, vt[i].eb, vt[i].eov, vt[i].eab, vt[i].epe});
    end

    for (int i = 0; i < 3000; i++) begin
      logic r, dv, sy, d;
      r  = ($urandom_range(0, 199) == 0);
      dv = ($urandom_range(0, 9) < 7);
      sy = ($urandom_range(0, 11) == 0);
      d  = logic'($urandom_range(0, 1));
      step(r, dv, sy, d);
      check($sformatf("rand%0d", i), {a_out, b_out, out_valid, abort, par_err},
            {m_a, m_b, m_ov, m_ab, m_pe});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
